// File: rtl/issue_sched.sv
// Single-issue scheduler: picks one ready functional-unit queue per cycle and books
// its common-data-bus write-back slot so that no two results ever share a CDB cycle.
module issue_sched #(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 7,
   parameter int SLOT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready_int,
   input  logic              ready_mult,
   input  logic              ready_div,
   input  logic              ready_ld_buf,
   output logic              issue_int,
   output logic              issue_mult,
   output logic              issue_div,
   output logic              issue_ld_buf,
   output logic              div_busy,
   output logic              cdb_busy_next,
   output logic [SLOT_W-1:0] cdb_res
);

   localparam int CNT_W = $clog2(DIV_LAT);

   localparam logic [SLOT_W-1:0] BOOK_1    = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] BOOK_MULT = SLOT_W'(1) << (MULT_LAT - 1);
   localparam logic [SLOT_W-1:0] BOOK_DIV  = SLOT_W'(1) << (DIV_LAT - 1);
   localparam logic [CNT_W-1:0]  DIV_HOLD  = CNT_W'(DIV_LAT - 1);

   logic [SLOT_W-1:0] res_q, res_d;
   logic              rr_q, rr_d;
   logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;

   logic elig_int, elig_mult, elig_div, elig_ld;
   logic gnt_int, gnt_mult, gnt_div, gnt_ld;
   logic [SLOT_W-1:0] book;

   always_comb begin
      // res[k] books the CDB for k+1 cycles ahead, so latency L tests bit L-1
      elig_int  = ready_int    && !res_q[0];
      elig_ld   = ready_ld_buf && !res_q[0];
      elig_mult = ready_mult   && !res_q[MULT_LAT-1];
      elig_div  = ready_div    && !res_q[DIV_LAT-1] && (div_cnt_q == '0);

      gnt_int  = 1'b0;
      gnt_mult = 1'b0;
      gnt_div  = 1'b0;
      gnt_ld   = 1'b0;
      if (!reset) begin
         if (elig_div)                             gnt_div  = 1'b1;
         else if (elig_mult)                       gnt_mult = 1'b1;
         else if (elig_int && (!rr_q || !elig_ld)) gnt_int  = 1'b1;
         else if (elig_ld)                         gnt_ld   = 1'b1;
      end

      book = '0;
      if (gnt_div)               book = BOOK_DIV;
      else if (gnt_mult)         book = BOOK_MULT;
      else if (gnt_int || gnt_ld) book = BOOK_1;
      res_d = (res_q | book) >> 1;

      rr_d = rr_q;
      if (gnt_int)     rr_d = 1'b1;
      else if (gnt_ld) rr_d = 1'b0;

      div_cnt_d = div_cnt_q;
      if (gnt_div)                div_cnt_d = DIV_HOLD;
      else if (div_cnt_q != '0)   div_cnt_d = div_cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q     <= '0;
         rr_q      <= 1'b0;
         div_cnt_q <= '0;
      end else begin
         res_q     <= res_d;
         rr_q      <= rr_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   assign issue_int     = gnt_int;
   assign issue_mult    = gnt_mult;
   assign issue_div     = gnt_div;
   assign issue_ld_buf  = gnt_ld;
   assign div_busy      = (div_cnt_q != '0);
   assign cdb_busy_next = res_q[0];
   assign cdb_res       = res_q;

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: fixed stimulus sequence with hand-computed grants,
// reservation vectors and divider occupancy.
module tb_issue_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       ready_int, ready_mult, ready_div, ready_ld_buf;
   logic       issue_int, issue_mult, issue_div, issue_ld_buf;
   logic       div_busy, cdb_busy_next;
   logic [7:0] cdb_res;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [31:0] G_NONE = 32'h0;
   localparam logic [31:0] G_LD   = 32'h1;
   localparam logic [31:0] G_INT  = 32'h2;
   localparam logic [31:0] G_MULT = 32'h4;
   localparam logic [31:0] G_DIV  = 32'h8;

   issue_sched #(.MULT_LAT(4), .DIV_LAT(7), .SLOT_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .ready_int     (ready_int),
      .ready_mult    (ready_mult),
      .ready_div     (ready_div),
      .ready_ld_buf  (ready_ld_buf),
      .issue_int     (issue_int),
      .issue_mult    (issue_mult),
      .issue_div     (issue_div),
      .issue_ld_buf  (issue_ld_buf),
      .div_busy      (div_busy),
      .cdb_busy_next (cdb_busy_next),
      .cdb_res       (cdb_res)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] gnt();
      return {28'd0, issue_div, issue_mult, issue_int, issue_ld_buf};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ri, input logic rm, input logic rd, input logic rl);
      ready_int    = ri;
      ready_mult   = rm;
      ready_div    = rd;
      ready_ld_buf = rl;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(1, 1, 1, 1);
      check_eq("rst_gnt", gnt(), G_NONE);
      check_eq("rst_res", 32'(cdb_res), 32'h0);
      check_eq("rst_divbusy", 32'(div_busy), 32'h0);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0);
      check_eq("idle_res", 32'(cdb_res), 32'h0);

      // fairness: int and ld_buf alternate starting with int
      for (int i = 0; i < 6; i++) begin
         tick();
         drive(1, 0, 0, 1);
         check_eq($sformatf("fair_%0d", i), gnt(), (i % 2 == 0) ? G_INT : G_LD);
      end

      // single source int
      for (int i = 0; i < 5; i++) begin
         tick();
         drive(1, 0, 0, 0);
         check_eq($sformatf("single_gnt_%0d", i), gnt(), G_INT);
         check_eq($sformatf("single_res_%0d", i), 32'(cdb_res), 32'h0);
      end
      tick();
      drive(0, 0, 0, 0);

      // mult/int collision on the CDB
      tick(); drive(0, 1, 0, 0);
      check_eq("coll_t0_gnt", gnt(), G_MULT);
      tick(); drive(1, 0, 0, 0);
      check_eq("coll_t1_gnt", gnt(), G_INT);
      check_eq("coll_t1_res", 32'(cdb_res), 32'h04);
      tick(); drive(1, 0, 0, 0);
      check_eq("coll_t2_gnt", gnt(), G_INT);
      check_eq("coll_t2_res", 32'(cdb_res), 32'h02);
      tick(); drive(1, 0, 0, 0);
      check_eq("coll_t3_gnt", gnt(), G_NONE);
      check_eq("coll_t3_busy", 32'(cdb_busy_next), 32'h1);
      check_eq("coll_t3_res", 32'(cdb_res), 32'h01);
      tick(); drive(1, 0, 0, 0);
      check_eq("coll_t4_gnt", gnt(), G_INT);
      tick(); drive(1, 0, 0, 0);
      check_eq("coll_t5_gnt", gnt(), G_INT);
      tick(); drive(0, 0, 0, 0);

      // divider occupancy with ready_div held
      tick(); drive(0, 0, 1, 0);
      check_eq("div_t0_gnt", gnt(), G_DIV);
      for (int i = 1; i <= 6; i++) begin
         tick(); drive(0, 0, 1, 0);
         check_eq($sformatf("div_t%0d_gnt", i), gnt(), G_NONE);
         check_eq($sformatf("div_t%0d_busy", i), 32'(div_busy), 32'h1);
         check_eq($sformatf("div_t%0d_res", i), 32'(cdb_res), 32'h40 >> i);
      end
      tick(); drive(0, 0, 1, 0);
      check_eq("div_t7_gnt", gnt(), G_DIV);
      check_eq("div_t7_busy", 32'(div_busy), 32'h0);
      for (int i = 0; i < 7; i++) begin
         tick(); drive(0, 0, 0, 0);
      end
      check_eq("div_drained", 32'(div_busy), 32'h0);

      // priority, then mult blocked by the div write-back slot
      tick(); drive(1, 1, 1, 1);
      check_eq("prio_t0_gnt", gnt(), G_DIV);
      tick(); drive(0, 0, 0, 0);
      tick(); drive(0, 0, 0, 0);
      tick(); drive(0, 1, 0, 0);
      check_eq("prio_t3_gnt", gnt(), G_NONE);
      check_eq("prio_t3_res", 32'(cdb_res), 32'h08);
      tick(); drive(0, 1, 0, 0);
      check_eq("prio_t4_gnt", gnt(), G_MULT);
      check_eq("prio_t4_res", 32'(cdb_res), 32'h04);
      // div blocked by div_busy must not block mult
      tick(); drive(0, 1, 1, 0);
      check_eq("prio_t5_gnt", gnt(), G_MULT);
      check_eq("prio_t5_busy", 32'(div_busy), 32'h1);

      // asynchronous reset mid-operation (rr currently prefers ld_buf)
      tick(); drive(0, 0, 0, 0);
      check_eq("pre_rst_res", 32'(cdb_res), 32'h07);
      check_eq("pre_rst_busy", 32'(div_busy), 32'h1);
      #2;
      reset = 1'b1;
      drive(1, 1, 1, 1);
      check_eq("arst_gnt", gnt(), G_NONE);
      check_eq("arst_res", 32'(cdb_res), 32'h0);
      check_eq("arst_divbusy", 32'(div_busy), 32'h0);
      check_eq("arst_cdbnext", 32'(cdb_busy_next), 32'h0);
      tick();
      check_eq("arst_hold_gnt", gnt(), G_NONE);
      reset = 1'b0;
      drive(1, 0, 0, 1);
      check_eq("post_rst_gnt0", gnt(), G_INT);
      tick(); drive(1, 0, 0, 1);
      check_eq("post_rst_gnt1", gnt(), G_LD);
      tick(); drive(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/issue_sched.md
Name: issue_sched

Overview:
- Issue scheduler for the out-of-order core. Each cycle it picks at most one ready functional-unit queue (int, mult, div, ld_buf) to issue from.
- It books the common data bus (CDB) write-back slot that the issued instruction will occupy, so no two results ever collide on the CDB.
- It drives the per-queue issue strobes. It also tracks the non-pipelined divider's busy period.

Parameters:
- MULT_LAT, 4: cycles from mult issue to mult CDB write-back (pipelined).
- DIV_LAT, 7: cycles from div issue to div CDB write-back. The divider is not pipelined.
- SLOT_W, 8: width of the CDB reservation register. Must satisfy SLOT_W >= DIV_LAT, SLOT_W >= MULT_LAT and DIV_LAT >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready_int  in  1  int queue has a ready instruction (latency 1).
- ready_mult  in  1  mult queue has a ready instruction.
- ready_div  in  1  div queue has a ready instruction.
- ready_ld_buf  in  1  load buffer has a ready entry (latency 1).
- issue_int  out  1  grant to int queue this cycle.
- issue_mult  out  1  grant to mult queue this cycle.
- issue_div  out  1  grant to div queue this cycle.
- issue_ld_buf  out  1  grant to ld_buf this cycle.
- div_busy  out  1  divider occupied; ready_div is ignored while high.
- cdb_busy_next  out  1  CDB already booked for the next cycle (equals res[0]).
- cdb_res  out  SLOT_W  reservation vector, for debug and coverage.

Behaviour:
- State: res[SLOT_W-1:0]; rr (0 = int preferred, 1 = ld_buf preferred); div_cnt (counter sized for DIV_LAT-1).
- Meaning of res[k] at cycle t: the CDB is booked for cycle t+1+k.
- A unit with latency L is eligible when its ready input is 1 and res[L-1] == 0.
  - Div additionally requires div_busy == 0.
  - int and ld_buf use res[0].
- Grant priority, combinational within the cycle: div > mult > {int, ld_buf}.
  - Between int and ld_buf the pick is round-robin on rr.
  - The unit preferred by rr wins when both are eligible.
  - After an int or ld_buf grant, rr points to the other unit.
  - rr is unchanged on mult or div grants.
- Grants are one-hot or zero, and always 0 while reset is high.
- Register update on every edge: res <= (res | G) >> 1, zero-filled.
  - G = 1 << (L-1) for the granted unit.
  - G = 0 if there is no grant.
- Divider tracking:
  - On a div grant, div_cnt <= DIV_LAT-1.
  - Otherwise, if div_cnt != 0, div_cnt decrements by 1.
  - div_busy = (div_cnt != 0).
  - After a div issued at cycle t, the next div can issue at t+DIV_LAT at the earliest.
- A blocked higher-priority unit does not block lower ones. For example, div blocked by div_busy still lets mult issue.
- Reset (asynchronous, including mid-operation): res = 0, rr = 0, div_cnt = 0. All outputs read 0 immediately. In-flight bookings are discarded.
- There is no back-pressure on grants. A queue must drop its ready in the cycle after a grant if it has nothing further to issue.

Test Plan:
- Reset: assert reset mid-sequence with res nonzero and div_busy = 1 -> all issue_* = 0, cdb_res = 0, div_busy = 0 with no clock edge; first grant after release is int when int and ld_buf are both ready.
- Single source: ready_int held high 5 cycles -> issue_int = 1 every cycle; cdb_res stays 0.
- Mult/int collision: mult granted at t0 with ready_int held t1..t5 -> issue_int at t1, t2; blocked at t3 (cdb_busy_next = 1, cdb_res = 8'h01); issue_int again at t4, t5.
- Div occupancy: ready_div held continuously, div granted at t0 -> div_busy = 1 for t1..t6; next issue_div at t7; cdb_res at t1 = 8'h20.
- Fairness: ready_int and ready_ld_buf both held for 6 cycles -> grants alternate int, ld_buf, int, ld_buf, int, ld_buf.
- Priority and slot conflict: all four ready at t0 -> issue_div. Then ready_mult alone at t3 -> blocked by res[3] (div slot t7); issue_mult at t4.
